// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : load_store_unit                                              |
// | Brief   : Multi-cycle data-memory access stage with request/ack bus,   |
// |           store lane steering, load extension and wait timeout.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_read_data, r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_bus_req, r_bus_we, r_timeout;
  logic        r_is_load, r_unsigned;
  logic [1:0]  r_size, r_offset;

  logic        w_access, w_byte, w_half, w_misalign, w_start, w_expire;
  logic [31:0] w_wdata, w_load;
  logic [3:0]  w_be;
  logic [7:0]  w_byte_sel;
  logic [15:0] w_half_sel;

  assign w_access   = mem_read | mem_write;
  assign w_byte     = (mem[1:0] == 2'b00);
  assign w_half     = (mem[1:0] == 2'b01);
  assign w_misalign = (w_half & addr[0]) | (~w_byte & ~w_half & (addr[1:0] != 2'b00));
  assign w_start    = (r_state == S_IDLE) & w_access & ~w_misalign;
  assign w_expire   = (r_state == S_REQ) & ~bus_ack & (r_wait_cnt == c_wait_last);

  assign stall      = w_start | (r_state == S_REQ);
  assign misaligned = (r_state == S_IDLE) & w_access & w_misalign;
  assign read_data  = r_read_data;
  assign timeout    = r_timeout;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_be     = r_bus_be;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_REQ;
      S_REQ:   if (bus_ack || w_expire) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Store lanes are replicated so the addressed bytes carry the operand.
  always_comb begin
    w_wdata = write_data;
    w_be    = 4'b1111;
    if (mem_write) begin
      if (w_byte) begin
        w_wdata = {4{write_data[7:0]}};
        w_be    = 4'b0001 << addr[1:0];
      end else if (w_half) begin
        w_wdata = {2{write_data[15:0]}};
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  always_comb begin
    w_byte_sel = bus_rdata[7:0];
    case (r_offset)
      2'd1:    w_byte_sel = bus_rdata[15:8];
      2'd2:    w_byte_sel = bus_rdata[23:16];
      2'd3:    w_byte_sel = bus_rdata[31:24];
      default: w_byte_sel = bus_rdata[7:0];
    endcase
    w_half_sel = r_offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte_sel[7]}}, w_byte_sel};
      2'b01:   w_load = {{16{~r_unsigned & w_half_sel[15]}}, w_half_sel};
      default: w_load = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_timeout   <= 1'b0;
      r_wait_cnt  <= '0;
      r_is_load   <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= '0;
      r_offset    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_write;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_bus_be    <= w_be;
            r_is_load   <= ~mem_write;
            r_unsigned  <= mem[2];
            r_size      <= mem[1:0];
            r_offset    <= addr[1:0];
            r_wait_cnt  <= '0;
          end
        end
        S_REQ: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          // An ack on the limit cycle takes precedence over the timeout.
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            if (r_is_load) r_read_data <= w_load;
          end else if (w_expire) begin
            r_bus_req <= 1'b0;
            r_timeout <= 1'b1;
            if (r_is_load) r_read_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_load_store_unit                                           |
// | Brief   : Directed self-checking bench for load_store_unit.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  mem = 3'b000;
  logic [31:0] addr = '0, write_data = '0, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] read_data, bus_addr, bus_wdata;
  logic        stall, misaligned, timeout, bus_req, bus_we;
  logic [3:0]  bus_be;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rd = '0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        tmo;
    int          req_cycles;
  } exp_t;

  exp_t sb[$];

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem(mem), .addr(addr), .write_data(write_data), .read_data(read_data),
    .stall(stall), .misaligned(misaligned), .timeout(timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic wr, input logic [2:0] m, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdat,
                                 input int waits, input logic [31:0] prev);
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    logic        ack;
    ack          = (waits >= 0) && (waits < MW);
    e.we         = wr;
    e.addr       = {a[31:2], 2'b00};
    e.tmo        = !ack;
    e.req_cycles = ack ? waits + 1 : MW;
    e.be         = 4'hF;
    e.wdata      = wd;
    b = rdat[8*a[1:0] +: 8];
    h = rdat[16*a[1] +: 16];
    if (wr) begin
      if (m[1:0] == 2'b00) begin
        e.be = 4'b0001 << a[1:0];
        e.wdata = {4{wd[7:0]}};
      end else if (m[1:0] == 2'b01) begin
        e.be = a[1] ? 4'b1100 : 4'b0011;
        e.wdata = {2{wd[15:0]}};
      end
      e.rdata = prev;
    end else if (!ack) begin
      e.rdata = '0;
    end else if (m[1:0] == 2'b00) begin
      e.rdata = m[2] ? {24'b0, b} : {{24{b[7]}}, b};
    end else if (m[1:0] == 2'b01) begin
      e.rdata = m[2] ? {16'b0, h} : {{16{h[15]}}, h};
    end else begin
      e.rdata = rdat;
    end
    return e;
  endfunction

  // Called at a negedge while the DUT is idle; returns at a negedge in IDLE.
  // waits = number of unacked REQ cycles before ack; -1 means never ack.
  task automatic access(input logic rd, input logic wr, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int waits);
    exp_t e;
    int   n;
    sb.push_back(model(wr, m, a, wd, rdat, waits, model_rd));
    mem_read = rd; mem_write = wr; mem = m; addr = a; write_data = wd;
    bus_rdata = rdat; bus_ack = 1'b0;
    #1;
    chk("stall_idle", 32'(stall), 32'd1);
    chk("misaligned_idle", 32'(misaligned), 32'd0);
    @(negedge clk);
    e = sb.pop_front();
    chk("bus_req_start", 32'(bus_req), 32'd1);
    chk("bus_we", 32'(bus_we), 32'(e.we));
    chk("bus_be", 32'(bus_be), 32'(e.be));
    n = 0;
    while (bus_req === 1'b1 && n < 300) begin
      chk("bus_addr_hold", bus_addr, e.addr);
      if (wr) chk("bus_wdata_hold", bus_wdata, e.wdata);
      chk("stall_req", 32'(stall), 32'd1);
      bus_ack = (n == waits);
      n++;
      @(negedge clk);
      bus_ack = 1'b0;
    end
    chk("req_cycles", 32'(n), 32'(e.req_cycles));
    chk("stall_done", 32'(stall), 32'd0);
    chk("bus_req_done", 32'(bus_req), 32'd0);
    chk("timeout_done", 32'(timeout), 32'(e.tmo));
    chk("read_data_done", read_data, e.rdata);
    model_rd = e.rdata;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("timeout_clear", 32'(timeout), 32'd0);
  endtask

  task automatic misaligned_try(input logic wr, input logic [2:0] m, input logic [31:0] a);
    mem_read = ~wr; mem_write = wr; mem = m; addr = a; bus_ack = 1'b0;
    #1;
    chk("misaligned_flag", 32'(misaligned), 32'd1);
    chk("misaligned_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("misaligned_no_req", 32'(bus_req), 32'd0);
    chk("misaligned_rd_hold", read_data, model_rd);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);   // SW
    access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);   // SB
    access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1);   // SH upper
    access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_0033, 32'h0, 2);   // SB lane 1
    access(1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h1280_FF34, 3);   // LB
    access(1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'h0, 32'h1280_FF34, 0);   // LBU
    misaligned_try(1'b0, 3'b001, 32'h0000_0301);                           // LH odd
    access(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0, 32'h8001_5555, 1);   // LH
    access(1'b1, 1'b0, 3'b101, 32'h0000_0300, 32'h0, 32'h1234_F00D, 0);   // LHU
    misaligned_try(1'b1, 3'b010, 32'h0000_0401);                           // SW off
    misaligned_try(1'b0, 3'b110, 32'h0000_0402);                           // word-coded
    access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'hAAAA_5555, -1);  // LW timeout
    access(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 3);   // ack on limit
    access(1'b1, 1'b0, 3'b011, 32'h0000_0408, 32'h0, 32'h1357_9BDF, 0);   // 011 as word
    access(1'b0, 1'b1, 3'b010, 32'h0000_0410, 32'h0BAD_CAFE, 32'h0, -1);  // SW timeout

    // Reset while the bus request is outstanding.
    mem_read = 1'b1; mem = 3'b010; addr = 32'h0000_0500;
    @(negedge clk);
    chk("mid_req_bus_req", 32'(bus_req), 32'd1);
    #2;
    reset = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("async_rst_bus_req", 32'(bus_req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_read_data", read_data, 32'd0);
    chk("post_rst_timeout", 32'(timeout), 32'd0);
    chk("post_rst_bus_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    model_rd = '0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
